// File: rtl/spram_param.sv
// spram_param: byte-enabled single-port RAM that zero-clears itself after reset; SPRAM_PARAM_OUTREG_EN adds a second read register stage.
module spram_param #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 16,
    localparam int BE_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              me,
    input  logic              wen,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              ready,
    output logic              err
);
    typedef enum logic {CLEAR, RUN} state_t;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    state_t state_q, state_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic err_q, err_d;
    logic rv1_q, rv1_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic clearing, wr_en;
    assign clearing = state_q == CLEAR;
    assign ready = state_q == RUN;
    assign wr_en = ready & me & wen;
    assign err = err_q;
    always_comb begin
        cnt_d = clearing ? cnt_q + 1'b1 : cnt_q;
        state_d = (clearing && cnt_d == DEPTH) ? RUN : state_q;
        err_d = err_q | (me & ~ready);
        rv1_d = ready & me & ~wen;
        rd1_d = rv1_d ? mem[addr] : rd1_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q <= '0;
            err_q <= 1'b0;
            rv1_q <= 1'b0;
            rd1_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            rv1_q <= rv1_d;
            rd1_q <= rd1_d;
        end
    end
    // Memory has no reset of its own; the clear sweep provides the zero contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clearing)
                mem[cnt_q[ADDR_W-1:0]] <= '0;
            else if (wr_en)
                for (int k = 0; k < BE_W; k++)
                    if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
        end
    end
`ifdef SPRAM_PARAM_OUTREG_EN
    logic rv2_q, rv2_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    always_comb begin
        rv2_d = rv1_q;
        rd2_d = rv1_q ? rd1_q : rd2_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            rv2_q <= 1'b0;
            rd2_q <= '0;
        end else begin
            rv2_q <= rv2_d;
            rd2_q <= rd2_d;
        end
    end
    assign rdata = rd2_q;
    assign rvalid = rv2_q;
`else
    assign rdata = rd1_q;
    assign rvalid = rv1_q;
`endif
endmodule

// File: tb/tb_spram_param.sv
// tb_spram_param: scoreboard bench for spram_param (DATA_W=64, ADDR_W=4); honours SPRAM_PARAM_OUTREG_EN latency.
module tb_spram_param;
`ifdef SPRAM_PARAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic me = 1'b0;
    logic wen = 1'b0;
    logic [7:0] be = '0;
    logic [3:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [63:0] rdata;
    logic rvalid, ready, err;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [63:0] exp_d[$];
    int exp_c[$];

    spram_param #(.DATA_W(64), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .me(me), .wen(wen), .be(be), .addr(addr),
        .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .ready(ready), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rvalid) begin
            checks++;
            if (exp_d.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rvalid: rdata=%h with no read outstanding", rdata);
            end else begin
                logic [63:0] ed;
                int ec;
                ed = exp_d.pop_front();
                ec = exp_c.pop_front();
                if (rdata !== ed || cyc != ec) begin
                    failures++;
                    $display("FAIL read_data: got %h at cycle %0d, expected %h at cycle %0d", rdata, cyc, ed, ec);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic m, input logic w, input logic [7:0] b, input logic [3:0] a, input logic [63:0] d);
        @(posedge clk);
        #1;
        me = m;
        wen = w;
        be = b;
        addr = a;
        wdata = d;
    endtask

    task automatic wr(input logic [3:0] a, input logic [63:0] d, input logic [7:0] b);
        drive(1'b1, 1'b1, b, a, d);
    endtask

    task automatic rd(input logic [3:0] a, input logic [63:0] e, input bit expect_valid);
        drive(1'b1, 1'b0, 8'hA5, a, '0);
        if (expect_valid) begin
            exp_d.push_back(e);
            exp_c.push_back(cyc + LAT);
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && exp_d.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_d.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d reads still outstanding, expected 0", name, exp_d.size());
        end
        exp_d.delete();
        exp_c.delete();
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        reset = 1'b1;
        me = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b0 || rvalid !== 1'b0 || err !== 1'b0 || rdata !== 64'h0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b rvalid=%b err=%b rdata=%h, expected 0 0 0 0", ready, rvalid, err, rdata);
        end
        reset = 1'b0;
    endtask

    task automatic count_clear(input string name);
        int n;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (ready === 1'b1) break;
            n++;
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL %s_clear_cycles: ready low for %0d cycles, expected 16", name, n);
        end
    endtask

    task automatic test_reset();
        do_reset(3);
        count_clear("reset");
        for (int a = 0; a < 16; a++) rd(4'(a), 64'h0, 1'b1);
        idle();
        drain("reset");
    endtask

    task automatic test_byte_enable();
        wr(4'd3, 64'h1122334455667788, 8'hFF);
        wr(4'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        rd(4'd3, 64'h11223344AAAAAAAA, 1'b1);
        wr(4'd3, 64'hFFFFFFFFFFFFFFFF, 8'h00);
        rd(4'd3, 64'h11223344AAAAAAAA, 1'b1);
        wr(4'd3, 64'h0000CC0000000000, 8'h20);
        rd(4'd3, 64'h1122CC44AAAAAAAA, 1'b1);
        idle();
        drain("byte_enable");
    endtask

    task automatic test_back_to_back();
        wr(4'd1, 64'h1, 8'hFF);
        wr(4'd2, 64'h2, 8'hFF);
        wr(4'd3, 64'h3, 8'hFF);
        rd(4'd1, 64'h1, 1'b1);
        rd(4'd2, 64'h2, 1'b1);
        rd(4'd3, 64'h3, 1'b1);
        idle();
        drain("back_to_back");
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (rdata !== 64'h3 || rvalid !== 1'b0) begin
                failures++;
                $display("FAIL idle_hold: rdata=%h rvalid=%b, expected 3 and 0", rdata, rvalid);
            end
        end
    endtask

    task automatic test_raw();
        wr(4'd7, 64'hCAFEF00D12345678, 8'hFF);
        rd(4'd7, 64'hCAFEF00D12345678, 1'b1);
        wr(4'd15, 64'h0123456789ABCDEF, 8'hFF);
        rd(4'd15, 64'h0123456789ABCDEF, 1'b1);
        idle();
        drain("raw");
    endtask

    task automatic test_err();
        do_reset(1);
        idle();
        idle();
        idle();
        wr(4'd5, 64'hDEAD, 8'hFF);
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_early: err=%b, expected 0", err);
        end
        rd(4'd5, 64'h0, 1'b0);
        #1;
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_set: err=%b, expected 1", err);
        end
        idle();
        for (int i = 0; i < 40 && ready !== 1'b1; i++) @(negedge clk);
        rd(4'd5, 64'h0, 1'b1);
        idle();
        drain("err");
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: err=%b, expected 1", err);
        end
    endtask

    task automatic test_reset_mid_clear();
        do_reset(1);
        repeat (8) @(posedge clk);
        do_reset(1);
        count_clear("mid_clear");
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL mid_clear_err: err=%b, expected 0", err);
        end
        wr(4'd9, 64'h5555AAAA5555AAAA, 8'hFF);
        @(posedge clk);
        #1;
        reset = 1'b1;
        me = 1'b1;
        wen = 1'b0;
        addr = 4'd9;
        @(posedge clk);
        #1;
        me = 1'b0;
        reset = 1'b0;
        count_clear("run_reset");
        rd(4'd9, 64'h0, 1'b1);
        idle();
        drain("run_reset");
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_back_to_back();
        test_raw();
        test_err();
        test_reset_mid_clear();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spram_param.md
SPRAM_PARAM -- requirements
Module: spram_param

Interface
REQ-001 Parameter: DATA_W, default 64, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter: ADDR_W, default 16, address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter: BE_W, default DATA_W/8, byte-enable width (derived; not overridden).
REQ-004 Port: clk  input  1  single clock; all logic on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: me  input  1  memory enable; request valid this cycle.
REQ-007 Port: wen  input  1  1 = write, 0 = read; qualified by me.
REQ-008 Port: be  input  BE_W  byte write enables; bit k covers wdata[8k+7:8k].
REQ-009 Port: addr  input  ADDR_W  word address.
REQ-010 Port: wdata  input  DATA_W  write data.
REQ-011 Port: rdata  output  DATA_W  read data, registered.
REQ-012 Port: rvalid  output  1  one-cycle pulse marking rdata valid.
REQ-013 Port: ready  output  1  1 = requests accepted (not clearing).
REQ-014 Port: err  output  1  sticky; set when a request arrives while ready=0.

Function
REQ-015 Two states: CLEAR and RUN; reset forces CLEAR with clear counter = 0.
REQ-016 CLEAR: one word per cycle written to 0, addresses 0..DEPTH-1 ascending; ready=0.
REQ-017 CLEAR -> RUN on the cycle after address DEPTH-1 is cleared; clear occupies exactly DEPTH cycles; clear counter ADDR_W+1 bits, no wrap to 0 before exit.
REQ-018 RUN: ready=1 every cycle; no return to CLEAR except via reset.
REQ-019 Write (RUN, me=1, wen=1): for each k with be[k]=1, byte k of mem[addr] takes wdata byte k at the clock edge; bytes with be[k]=0 unchanged; be=0 is a legal no-op write.
REQ-020 Write SHALL NOT change rdata and SHALL NOT pulse rvalid.
REQ-021 Read (RUN, me=1, wen=0): rdata = mem[addr] and rvalid=1 at edge N+1 (base latency 1); be ignored.
REQ-022 Back-to-back reads every cycle SHALL yield one rvalid per read, in order, no bubbles.
REQ-023 Read of an address written in the previous cycle SHALL return the new data.
REQ-024 me=0: no memory access; rdata holds its last value (never driven to Z); rvalid=0.
REQ-025 Request with ready=0: ignored (no write, no read, no rvalid); err set to 1 the following edge.
REQ-026 err clears only on reset.

Reset
REQ-027 On reset edge: rdata=0, rvalid=0, ready=0, err=0, all pipeline valid bits=0, state=CLEAR, counter=0.
REQ-028 Reset asserted mid-CLEAR restarts clear from address 0; mid-RUN discards any in-flight read (no rvalid).
REQ-029 Reset held high: clearing does not advance; ready stays 0.

Configuration
REQ-030 Macro SPRAM_PARAM_OUTREG_EN defined: extra output register stage; read latency 2 (rdata/rvalid at N+2); throughput still one read per cycle; both stages reset to 0.
REQ-031 Macro undefined: read latency 1 per REQ-021; no extra stage.

Verification (DATA_W=64, ADDR_W=4, DEPTH=16)
REQ-032 Reset 1 cycle then release -> ready=0 for exactly 16 cycles, then 1; read of addr 0..15 returns 0x0 with rvalid.
REQ-033 Write addr 3 = 0x1122334455667788 be=0xFF, then write addr 3 wdata=0xAAAAAAAAAAAAAAAA be=0x0F, read addr 3 -> rdata=0x11223344AAAAAAAA, rvalid at latency 1 (2 with macro).
REQ-034 Reads addr 1,2,3 on consecutive cycles after writing 0x1,0x2,0x3 -> rvalid high 3 consecutive cycles, rdata 0x1,0x2,0x3 in order; me=0 afterwards -> rdata holds 0x3, rvalid=0.
REQ-035 Write addr 5 = 0xDEAD during CLEAR cycle 4 -> err=1 next cycle, after clear read addr 5 = 0x0.
REQ-036 Reset re-asserted at CLEAR cycle 8, released -> ready=0 for full 16 cycles again; err=0.
REQ-037 Write addr 7 then read addr 7 next cycle -> rdata equals written data.
